load_store_unit: RTL
====================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have no parameters; data and address width fixed at 32 bits.
REQ-002 SHALL use one clock; reset is asynchronous and active-low: clk input 1 (rising-edge clock), rst_n input 1 (async active-low reset).
REQ-003 SHALL have: valid_i input 1, execute-stage op valid; ready_o output 1, unit can accept an op.
REQ-004 SHALL have: alu_result_i input 32, ALU result (effective address for memory ops); store_data_i input 32, rs2 value.
REQ-005 SHALL have: is_load_i input 1; is_store_i input 1; funct3_i input 3, RV32I width code; rd_i input 5, destination register.
REQ-006 SHALL have: mem_req_o output 1; mem_we_o output 1; mem_addr_o output 32, word-aligned; mem_be_o output 4; mem_wdata_o output 32.
REQ-007 SHALL have: mem_gnt_i input 1, request accepted; mem_rvalid_i input 1, read data valid; mem_rdata_i input 32.
REQ-008 SHALL have: wb_valid_o output 1; wb_we_o output 1; wb_rd_o output 5; wb_data_o output 32; fault_o output 1.

Function
REQ-009 SHALL implement FSM states IDLE, REQ, WAIT_R; ready_o = (state==IDLE).
REQ-010 SHALL accept an op when valid_i && ready_o, registering address, store data, funct3, rd and op type.
REQ-011 Non-memory op (is_load_i=0, is_store_i=0) accepted at cycle N: SHALL stay IDLE, drive wb_valid_o=1, wb_data_o=alu_result_i, wb_rd_o=rd_i at N+1 (1-cycle pulse).
REQ-012 If is_load_i and is_store_i are both 1: SHALL treat the op as illegal (fault).
REQ-013 Legal funct3: loads 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores 000 SB, 001 SH, 010 SW; anything else illegal.
REQ-014 Misaligned: halfword with addr[0]=1, word with addr[1:0]!=0.
REQ-015 Illegal or misaligned memory op: SHALL make no memory request, stay IDLE, pulse fault_o=1 at N+1 with wb_valid_o=0.
REQ-016 Legal memory op: IDLE->REQ.
REQ-017 In REQ: mem_req_o=1 with stable mem_addr_o={addr[31:2],2'b00}, mem_we_o, mem_be_o, mem_wdata_o until the cycle mem_gnt_i=1.
REQ-018 Store byte enables: SB be=4'b0001<<addr[1:0], wdata={4{data[7:0]}}; SH be=4'b0011<<addr[1:0], wdata={2{data[15:0]}}; SW be=4'b1111, wdata=data.
REQ-019 Load byte enables: LB/LBU as SB, LH/LHU as SH, LW 4'b1111; mem_wdata_o=0.
REQ-020 Store granted at cycle M: SHALL go to IDLE at M+1 and pulse wb_valid_o=1, wb_we_o=0 at M+1.
REQ-021 Load granted at cycle M: SHALL go to WAIT_R; mem_req_o=0 in WAIT_R.
REQ-022 In WAIT_R: SHALL ignore mem_gnt_i; mem_rvalid_i is only sampled in WAIT_R (never in the grant cycle).
REQ-023 On mem_rvalid_i at cycle K: SHALL register extracted data, pulse wb_valid_o=1, wb_we_o=(rd!=0) at K+1, and return to IDLE.
REQ-024 Extraction: sel=mem_rdata_i>>(8*addr[1:0]); LB sign-extends sel[7:0]; LBU zero-extends; LH sign-extends sel[15:0]; LHU zero-extends; LW uses rdata unchanged.
REQ-025 Non-memory ops: wb_we_o=(rd!=0).
REQ-026 wb_data_o, wb_rd_o SHALL hold their last values when wb_valid_o=0.
REQ-027 Minimum latencies: non-memory 1 cycle; store 2 cycles (gnt at N+1); load 3 cycles (gnt N+1, rvalid N+2, wb N+3).
REQ-028 Unbounded gnt/rvalid wait SHALL be legal with no timeout.

Reset
REQ-029 rst_n low SHALL immediately force state=IDLE.
REQ-030 rst_n low SHALL force mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o, wb_valid_o, wb_we_o, wb_rd_o, wb_data_o, fault_o to 0.
REQ-031 Out of reset, ready_o SHALL be 1.
REQ-032 Reset during REQ or WAIT_R SHALL abandon the op: no wb pulse, and a late mem_rvalid_i in IDLE is ignored.

Verification
REQ-033 ADD pass-through: alu_result_i=0x0000_1234, rd=5 -> next cycle wb_valid_o=1, wb_we_o=1, wb_data_o=0x1234, wb_rd_o=5.
REQ-034 SB: addr=0x1003, rs2=0xAABBCCDD, gnt after 2 wait cycles -> mem_addr_o=0x1000, be=1000, wdata=0xDDDDDDDD held 3 cycles; wb_we_o=0 pulse after gnt.
REQ-035 LH: addr=0x2002, rdata=0x8001_0000 -> be=1100, wb_data_o=0xFFFF8001.
REQ-036 LHU: same stimulus as REQ-035 -> wb_data_o=0x00008001.
REQ-037 LW to rd=0 -> wb_we_o=0.
REQ-038 Misaligned LW at 0x0000_0006 -> fault_o=1 for one cycle, mem_req_o never asserted, ready_o stays 1.
REQ-039 Reset in WAIT_R, then rvalid -> no wb_valid_o pulse, ready_o=1.

Source files
------------

// File: rtl/load_store_unit.sv
// RV32I load/store unit: one op in flight, single memory request port with
// grant/rvalid handshakes, and a registered writeback/fault pulse interface.
module load_store_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid_i,
  output logic        ready_o,
  input  logic [31:0] alu_result_i,
  input  logic [31:0] store_data_i,
  input  logic        is_load_i,
  input  logic        is_store_i,
  input  logic [2:0]  funct3_i,
  input  logic [4:0]  rd_i,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  output logic        wb_valid_o,
  output logic        wb_we_o,
  output logic [4:0]  wb_rd_o,
  output logic [31:0] wb_data_o,
  output logic        fault_o
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] REQ    = 2'd1;
  localparam logic [1:0] WAIT_R = 2'd2;

  logic [1:0]  state_r;
  logic [2:0]  funct3_r;
  logic [4:0]  rd_r;
  logic [1:0]  off_r;
  logic        is_load_r;
  logic        mem_req_r, mem_we_r, wb_valid_r, wb_we_r, fault_r;
  logic [31:0] mem_addr_r, mem_wdata_r, wb_data_r;
  logic [3:0]  mem_be_r;
  logic [4:0]  wb_rd_r;

  logic        is_mem_s, illegal_s, misaligned_s, fault_s;
  logic [3:0]  be_s;
  logic [31:0] wdata_s, load_data_s;

  // Lane select and sign/zero extension of returned read data.
  function automatic logic [31:0] extract(input logic [31:0] rdata,
                                          input logic [1:0]  off,
                                          input logic [2:0]  f3);
    logic [31:0] sel;
    sel = rdata >> {off, 3'b000};
    case (f3)
      3'b000:  extract = {{24{sel[7]}}, sel[7:0]};
      3'b001:  extract = {{16{sel[15]}}, sel[15:0]};
      3'b100:  extract = {24'd0, sel[7:0]};
      3'b101:  extract = {16'd0, sel[15:0]};
      default: extract = rdata;
    endcase
  endfunction

  // Decode legality, alignment, byte enables and store lane replication.
  always_comb begin
    is_mem_s = is_load_i | is_store_i;
    if (is_load_i && is_store_i) begin
      illegal_s = 1'b1;
    end else if (is_load_i) begin
      illegal_s = (funct3_i[1:0] == 2'b11) | (funct3_i[2] & funct3_i[1]);
    end else if (is_store_i) begin
      illegal_s = funct3_i[2] | (funct3_i[1:0] == 2'b11);
    end else begin
      illegal_s = 1'b0;
    end
    case (funct3_i[1:0])
      2'b00: begin
        misaligned_s = 1'b0;
        be_s         = 4'b0001 << alu_result_i[1:0];
        wdata_s      = {4{store_data_i[7:0]}};
      end
      2'b01: begin
        misaligned_s = alu_result_i[0];
        be_s         = 4'b0011 << alu_result_i[1:0];
        wdata_s      = {2{store_data_i[15:0]}};
      end
      2'b10: begin
        misaligned_s = (alu_result_i[1:0] != 2'b00);
        be_s         = 4'b1111;
        wdata_s      = store_data_i;
      end
      default: begin
        misaligned_s = 1'b0;
        be_s         = 4'b0000;
        wdata_s      = 32'd0;
      end
    endcase
    fault_s     = illegal_s | misaligned_s;
    load_data_s = extract(mem_rdata_i, off_r, funct3_r);
  end

  // Control FSM plus all registered memory and writeback outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      funct3_r    <= 3'd0;
      rd_r        <= 5'd0;
      off_r       <= 2'd0;
      is_load_r   <= 1'b0;
      mem_req_r   <= 1'b0;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= 32'd0;
      mem_be_r    <= 4'd0;
      mem_wdata_r <= 32'd0;
      wb_valid_r  <= 1'b0;
      wb_we_r     <= 1'b0;
      wb_rd_r     <= 5'd0;
      wb_data_r   <= 32'd0;
      fault_r     <= 1'b0;
    end else begin
      wb_valid_r <= 1'b0;
      wb_we_r    <= 1'b0;
      fault_r    <= 1'b0;
      case (state_r)
        IDLE: begin
          if (valid_i && !is_mem_s) begin
            wb_valid_r <= 1'b1;
            wb_we_r    <= (rd_i != 5'd0);
            wb_data_r  <= alu_result_i;
            wb_rd_r    <= rd_i;
          end else if (valid_i && fault_s) begin
            fault_r <= 1'b1;
          end else if (valid_i) begin
            state_r     <= REQ;
            mem_req_r   <= 1'b1;
            mem_we_r    <= is_store_i;
            mem_addr_r  <= {alu_result_i[31:2], 2'b00};
            mem_be_r    <= be_s;
            mem_wdata_r <= is_store_i ? wdata_s : 32'd0;
            funct3_r    <= funct3_i;
            rd_r        <= rd_i;
            off_r       <= alu_result_i[1:0];
            is_load_r   <= is_load_i;
          end
        end
        REQ: begin
          if (mem_gnt_i) begin
            mem_req_r <= 1'b0;
            mem_we_r  <= 1'b0;
            if (is_load_r) begin
              state_r <= WAIT_R;
            end else begin
              state_r    <= IDLE;
              wb_valid_r <= 1'b1;
            end
          end
        end
        WAIT_R: begin
          if (mem_rvalid_i) begin
            state_r    <= IDLE;
            wb_valid_r <= 1'b1;
            wb_we_r    <= (rd_r != 5'd0);
            wb_rd_r    <= rd_r;
            wb_data_r  <= load_data_s;
          end
        end
        default: state_r <= IDLE;
      endcase
    end
  end

  assign ready_o     = (state_r == IDLE);
  assign mem_req_o   = mem_req_r;
  assign mem_we_o    = mem_we_r;
  assign mem_addr_o  = mem_addr_r;
  assign mem_be_o    = mem_be_r;
  assign mem_wdata_o = mem_wdata_r;
  assign wb_valid_o  = wb_valid_r;
  assign wb_we_o     = wb_we_r;
  assign wb_rd_o     = wb_rd_r;
  assign wb_data_o   = wb_data_r;
  assign fault_o     = fault_r;

endmodule
